// File: rtl/button_autorepeat_if.sv
// rtl/button_autorepeat_if.sv - button level inputs and event/held outputs of the autorepeat block
interface button_autorepeat_if #(
    parameter int N_BTN = 4
);
    logic             en;
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] pulse;
    logic [N_BTN-1:0] held;
    logic             any_pulse;

    modport master (
        output en,
        output btn_in,
        input  pulse,
        input  held,
        input  any_pulse
    );

    modport slave (
        input  en,
        input  btn_in,
        output pulse,
        output held,
        output any_pulse
    );
endinterface

// File: rtl/button_autorepeat.sv
// rtl/button_autorepeat.sv - per-channel press/DAS/ARR autorepeat turning debounced levels into event pulses
module button_autorepeat #(
    parameter int               N_BTN       = 4,
    parameter int               DAS_CYCLES  = 17_000_000,
    parameter int               ARR_CYCLES  = 5_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK = 4'b0111,
    parameter int               CNT_W       = 25
) (
    input  logic                clk,
    input  logic                reset,
    button_autorepeat_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q [N_BTN];
    state_t           state_d [N_BTN];
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [CNT_W-1:0] cnt_d   [N_BTN];
    logic [N_BTN-1:0] pulse_q, pulse_d;
    logic [N_BTN-1:0] held_q,  held_d;
    logic [N_BTN-1:0] das_done, arr_done;
    // Low only until the first clock after reset, so a button held through reset goes to HOLD.
    logic             armed_q, armed_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            pulse_q <= '0;
            held_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pulse_q <= pulse_d;
            held_q  <= held_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        das_done = '0;
        arr_done = '0;
        for (int i = 0; i < N_BTN; i++) begin
            das_done[i] = (cnt_q[i] == DAS_LAST);
            arr_done[i] = (cnt_q[i] == ARR_LAST);
        end
    end

    // Release is tested before en and before the terminal count, so it always wins.
    always_comb begin
        armed_d = 1'b1;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (bus.btn_in[i]) begin
                        cnt_d[i] = '0;
                        if (bus.en && armed_q && REPEAT_MASK[i]) begin
                            state_d[i] = ST_DELAY;
                        end else begin
                            state_d[i] = ST_HOLD;
                        end
                    end
                end
                ST_DELAY: begin
                    if (!bus.btn_in[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (!bus.en) begin
                        state_d[i] = ST_HOLD;
                        cnt_d[i]   = '0;
                    end else if (das_done[i]) begin
                        state_d[i] = ST_REPEAT;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (!bus.btn_in[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (!bus.en) begin
                        state_d[i] = ST_HOLD;
                        cnt_d[i]   = '0;
                    end else if (arr_done[i]) begin
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d[i] = '0;
                    if (!bus.btn_in[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pulse_d = '0;
        held_d  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            held_d[i] = (state_d[i] != ST_IDLE);
            if (bus.btn_in[i] && bus.en) begin
                case (state_q[i])
                    ST_IDLE:   pulse_d[i] = armed_q;
                    ST_DELAY:  pulse_d[i] = das_done[i];
                    ST_REPEAT: pulse_d[i] = arr_done[i];
                    default:   pulse_d[i] = 1'b0;
                endcase
            end
        end
    end

    assign bus.pulse     = pulse_q;
    assign bus.held      = held_q;
    assign bus.any_pulse = |pulse_q;

endmodule
